// File: rtl/pipe_pkg.sv
// Shared pipeline definitions used by the stage registers: stall
// encodings, the NOP record, stage indices, the stage-register action
// decode and the bubble-record layout.
package pipe_pkg;

  // Stall vector encodings, one bit per stage
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // NOP destination register and zero data word
  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  // Default stage indices into the stall vector
  localparam int unsigned STAGE_IF  = 0;
  localparam int unsigned STAGE_ID  = 1;
  localparam int unsigned STAGE_EX  = 2;
  localparam int unsigned STAGE_EXM = 3;
  localparam int unsigned STAGE_MEM = 4;
  localparam int unsigned STAGE_WB  = 5;

  localparam int unsigned CP0_ADDR_W = 5;

  // What a stage register does on a given edge
  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_HOLD    = 2'd1,
    ACT_BUBBLE  = 2'd2,
    ACT_FLUSH   = 2'd3
  } stage_act_e;

  // Fixed-width side-effect fields of a write-back record; the
  // parameter-width data fields are carried alongside this record.
  typedef struct packed {
    logic                  whilo;
    logic                  cp0_we;
    logic [CP0_ADDR_W-1:0] cp0_waddr;
    logic                  llbit_we;
    logic                  llbit_value;
  } wb_ctrl_t;

  localparam wb_ctrl_t BUBBLE_CTRL = '0;

  // Flush beats everything; a stall whose downstream stage keeps going
  // inserts a bubble; a stall with the downstream stage also stopped holds.
  function automatic stage_act_e decode_action(input logic stop_here,
                                               input logic stop_next,
                                               input logic flush_req);
    if (flush_req)
      return ACT_FLUSH;
    else if (stop_here == STOP && stop_next == NO_STOP)
      return ACT_BUBBLE;
    else if (stop_here == STOP)
      return ACT_HOLD;
    else
      return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise step unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // Count register, cleared asynchronously by the active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: latches register-file, HI/LO, CP0 and LLbit
// write-back side effects and presents them one cycle later.
// Optional bubble/flush statistics counters are built when MEM_WB_STATS_EN
// is defined; otherwise both counter ports read constant 0.
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_WCH = 1,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned STAGE   = STAGE_MEM,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_W-1:0]        stall,
  input  logic                      flush,
  input  logic [NUM_WCH*ADDR_W-1:0] mem_wd,
  input  logic [NUM_WCH-1:0]        mem_wreg,
  input  logic [NUM_WCH*DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0]         mem_hi,
  input  logic [DATA_W-1:0]         mem_lo,
  input  logic                      mem_whilo,
  input  logic                      mem_cp0_we,
  input  logic [4:0]                mem_cp0_waddr,
  input  logic [DATA_W-1:0]         mem_cp0_wdata,
  input  logic                      mem_llbit_we,
  input  logic                      mem_llbit_value,
  output logic [NUM_WCH*ADDR_W-1:0] wb_wd,
  output logic [NUM_WCH-1:0]        wb_wreg,
  output logic [NUM_WCH*DATA_W-1:0] wb_wdata,
  output logic [DATA_W-1:0]         wb_hi,
  output logic [DATA_W-1:0]         wb_lo,
  output logic                      wb_whilo,
  output logic                      wb_cp0_we,
  output logic [4:0]                wb_cp0_waddr,
  output logic [DATA_W-1:0]         wb_cp0_wdata,
  output logic                      wb_llbit_we,
  output logic                      wb_llbit_value,
  output logic                      wb_valid,
  output logic [CNT_W-1:0]          stat_bubble_cnt,
  output logic [CNT_W-1:0]          stat_flush_cnt
);

  stage_act_e action;

  logic [NUM_WCH*ADDR_W-1:0] wd_q, wd_d;
  logic [NUM_WCH-1:0]        wreg_q, wreg_d;
  logic [NUM_WCH*DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0]         hi_q, hi_d;
  logic [DATA_W-1:0]         lo_q, lo_d;
  logic [DATA_W-1:0]         cp0_wdata_q, cp0_wdata_d;
  wb_ctrl_t                  ctrl_q, ctrl_d;
  logic                      valid_q, valid_d;

  // Only our own stall bit and the downstream one matter here
  logic unused_stall;
  assign unused_stall = ^stall;

  // Decode this edge's action and build the next record; bubbles force
  // addresses and data to zero so forwarding comparators stay quiet
  always_comb begin
    action      = decode_action(stall[STAGE], stall[STAGE+1], flush);
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cp0_wdata_d = cp0_wdata_q;
    ctrl_d      = ctrl_q;
    valid_d     = valid_q;
    case (action)
      ACT_ADVANCE: begin
        wd_d        = mem_wd;
        wreg_d      = mem_wreg;
        wdata_d     = mem_wdata;
        hi_d        = mem_hi;
        lo_d        = mem_lo;
        cp0_wdata_d = mem_cp0_wdata;
        ctrl_d      = '{whilo:       mem_whilo,
                        cp0_we:      mem_cp0_we,
                        cp0_waddr:   mem_cp0_waddr,
                        llbit_we:    mem_llbit_we,
                        llbit_value: mem_llbit_value};
        valid_d     = 1'b1;
      end
      ACT_BUBBLE, ACT_FLUSH: begin
        wd_d        = {NUM_WCH{ADDR_W'(NOP_REG_ADDR)}};
        wreg_d      = '0;
        wdata_d     = {NUM_WCH{DATA_W'(ZERO_WORD)}};
        hi_d        = DATA_W'(ZERO_WORD);
        lo_d        = DATA_W'(ZERO_WORD);
        cp0_wdata_d = DATA_W'(ZERO_WORD);
        ctrl_d      = BUBBLE_CTRL;
        valid_d     = 1'b0;
      end
      default: ;  // hold: keep current record
    endcase
  end

  // Write-back record register; reset empties it asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q        <= '0;
      wreg_q      <= '0;
      wdata_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cp0_wdata_q <= '0;
      ctrl_q      <= BUBBLE_CTRL;
      valid_q     <= 1'b0;
    end else begin
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cp0_wdata_q <= cp0_wdata_d;
      ctrl_q      <= ctrl_d;
      valid_q     <= valid_d;
    end
  end

  assign wb_wd          = wd_q;
  assign wb_wreg        = wreg_q;
  assign wb_wdata       = wdata_q;
  assign wb_hi          = hi_q;
  assign wb_lo          = lo_q;
  assign wb_whilo       = ctrl_q.whilo;
  assign wb_cp0_we      = ctrl_q.cp0_we;
  assign wb_cp0_waddr   = ctrl_q.cp0_waddr;
  assign wb_cp0_wdata   = cp0_wdata_q;
  assign wb_llbit_we    = ctrl_q.llbit_we;
  assign wb_llbit_value = ctrl_q.llbit_value;
  assign wb_valid       = valid_q;

`ifdef MEM_WB_STATS_EN
  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (action == ACT_BUBBLE),
    .clr (1'b0),
    .q   (stat_bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (action == ACT_FLUSH),
    .clr (1'b0),
    .q   (stat_flush_cnt)
  );
`else
  assign stat_bubble_cnt = '0;
  assign stat_flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with two write channels and 4-bit
// statistics counters; expected counter values follow MEM_WB_STATS_EN.
module tb_mem_wb_stage;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int NUM_WCH = 2;
  localparam int STALL_W = 6;
  localparam int STAGE   = 4;
  localparam int CNT_W   = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [STALL_W-1:0]        stall;
  logic                      flush;
  logic [NUM_WCH*ADDR_W-1:0] mem_wd;
  logic [NUM_WCH-1:0]        mem_wreg;
  logic [NUM_WCH*DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0]         mem_hi, mem_lo, mem_cp0_wdata;
  logic                      mem_whilo, mem_cp0_we, mem_llbit_we, mem_llbit_value;
  logic [4:0]                mem_cp0_waddr;
  logic [NUM_WCH*ADDR_W-1:0] wb_wd;
  logic [NUM_WCH-1:0]        wb_wreg;
  logic [NUM_WCH*DATA_W-1:0] wb_wdata;
  logic [DATA_W-1:0]         wb_hi, wb_lo, wb_cp0_wdata;
  logic                      wb_whilo, wb_cp0_we, wb_llbit_we, wb_llbit_value, wb_valid;
  logic [4:0]                wb_cp0_waddr;
  logic [CNT_W-1:0]          stat_bubble_cnt, stat_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [CNT_W-1:0] exp_bub   = '0;
  logic [CNT_W-1:0] exp_flush = '0;

  always #5 clk = ~clk;

  mem_wb_stage #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WCH(NUM_WCH),
    .STALL_W(STALL_W), .STAGE(STAGE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .mem_cp0_we(mem_cp0_we), .mem_cp0_waddr(mem_cp0_waddr),
    .mem_cp0_wdata(mem_cp0_wdata), .mem_llbit_we(mem_llbit_we),
    .mem_llbit_value(mem_llbit_value),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
    .wb_cp0_we(wb_cp0_we), .wb_cp0_waddr(wb_cp0_waddr),
    .wb_cp0_wdata(wb_cp0_wdata), .wb_llbit_we(wb_llbit_we),
    .wb_llbit_value(wb_llbit_value), .wb_valid(wb_valid),
    .stat_bubble_cnt(stat_bubble_cnt), .stat_flush_cnt(stat_flush_cnt)
  );

  // One rising edge, then sample 1 ns later; one line per transaction
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    cyc++;
    $display("[%0d] %s stall=%b flush=%b wd=%h wreg=%b wdata=%h valid=%b bub=%0d fl=%0d",
             cyc, tag, stall, flush, wb_wd, wb_wreg, wb_wdata, wb_valid,
             stat_bubble_cnt, stat_flush_cnt);
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; stall = '0;
    mem_wd = '1; mem_wreg = '1; mem_wdata = '1;
    mem_hi = 32'hAAAA5555; mem_lo = 32'h5555AAAA; mem_whilo = 1'b1;
    mem_cp0_we = 1'b1; mem_cp0_waddr = 5'h1F; mem_cp0_wdata = 32'h0F0F0F0F;
    mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
    #12 rst = 1'b1;
    step("load");
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL rst_preload_valid: got %b expected 1", wb_valid); end
    n_checks++; if (wb_cp0_waddr !== 5'h1F) begin n_fail++; $display("FAIL rst_preload_cp0a: got %h expected 1f", wb_cp0_waddr); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo, wb_cp0_we, wb_cp0_waddr,
         wb_cp0_wdata, wb_llbit_we, wb_llbit_value} !== '0) begin
      n_fail++; $display("FAIL rst_async_outputs: got wd=%h wdata=%h hi=%h expected all 0", wb_wd, wb_wdata, wb_hi);
    end
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b expected 0", wb_valid); end
    n_checks++; if ({stat_bubble_cnt, stat_flush_cnt} !== '0) begin n_fail++; $display("FAIL rst_counters: got %h/%h expected 0/0", stat_bubble_cnt, stat_flush_cnt); end
    step("in_reset");
    n_checks++; if (wb_valid !== 1'b0 || wb_wdata !== '0) begin n_fail++; $display("FAIL rst_held: got valid=%b wdata=%h expected 0/0", wb_valid, wb_wdata); end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_advance();
    stall = '0; flush = 1'b0;
    mem_wd = {5'd0, 5'd3}; mem_wreg = 2'b01; mem_wdata = {32'h0, 32'hDEADBEEF};
    mem_hi = 32'h11112222; mem_lo = 32'h33334444; mem_whilo = 1'b1;
    mem_cp0_we = 1'b1; mem_cp0_waddr = 5'd12; mem_cp0_wdata = 32'hCAFE0001;
    mem_llbit_we = 1'b1; mem_llbit_value = 1'b0;
    step("advance");
    n_checks++; if (wb_wd !== 10'd3) begin n_fail++; $display("FAIL adv_wd: got %h expected 003", wb_wd); end
    n_checks++; if (wb_wreg !== 2'b01) begin n_fail++; $display("FAIL adv_wreg: got %b expected 01", wb_wreg); end
    n_checks++; if (wb_wdata !== {32'h0, 32'hDEADBEEF}) begin n_fail++; $display("FAIL adv_wdata: got %h expected 00000000deadbeef", wb_wdata); end
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL adv_valid: got %b expected 1", wb_valid); end
    n_checks++; if ({wb_hi, wb_lo, wb_whilo} !== {32'h11112222, 32'h33334444, 1'b1}) begin n_fail++; $display("FAIL adv_hilo: got %h %h %b expected 11112222 33334444 1", wb_hi, wb_lo, wb_whilo); end
    n_checks++; if ({wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata} !== {1'b1, 5'd12, 32'hCAFE0001}) begin n_fail++; $display("FAIL adv_cp0: got %b %h %h expected 1 0c cafe0001", wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata); end
    n_checks++; if ({wb_llbit_we, wb_llbit_value} !== 2'b10) begin n_fail++; $display("FAIL adv_llbit: got %b%b expected 10", wb_llbit_we, wb_llbit_value); end
  endtask

  task automatic test_bubble();
    n_checks++; if (stat_bubble_cnt !== exp_bub) begin n_fail++; $display("FAIL bub_cnt_before: got %0d expected %0d", stat_bubble_cnt, exp_bub); end
    stall = 6'b011111;
    step("bubble");
`ifdef MEM_WB_STATS_EN
    exp_bub = sat_inc(exp_bub);
`endif
    n_checks++; if (wb_wreg !== '0 || wb_wdata !== '0 || wb_wd !== '0) begin n_fail++; $display("FAIL bub_payload: got wreg=%b wd=%h wdata=%h expected zeros", wb_wreg, wb_wd, wb_wdata); end
    n_checks++; if ({wb_whilo, wb_cp0_we, wb_llbit_we, wb_hi} !== '0) begin n_fail++; $display("FAIL bub_ctrl: got whilo=%b cp0we=%b llwe=%b hi=%h expected zeros", wb_whilo, wb_cp0_we, wb_llbit_we, wb_hi); end
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL bub_valid: got %b expected 0", wb_valid); end
    n_checks++; if (stat_bubble_cnt !== exp_bub) begin n_fail++; $display("FAIL bub_cnt: got %0d expected %0d", stat_bubble_cnt, exp_bub); end
    n_checks++; if (stat_flush_cnt !== exp_flush) begin n_fail++; $display("FAIL bub_flush_cnt: got %0d expected %0d", stat_flush_cnt, exp_flush); end
  endtask

  task automatic test_hold_flush();
    stall = '0; flush = 1'b0;
    mem_wd = {5'd7, 5'd2}; mem_wreg = 2'b01; mem_wdata = {32'h0, 32'h1234};
    step("advance");
    stall = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      mem_wdata = {32'h9999, 32'h5678 + i}; mem_wreg = 2'b10; mem_wd = 10'h155;
      step("hold");
      n_checks++; if (wb_wdata !== {32'h0, 32'h1234} || wb_wreg !== 2'b01 || wb_wd !== {5'd7, 5'd2}) begin n_fail++; $display("FAIL hold_%0d: got wdata=%h wreg=%b wd=%h expected 1234/01/0e2", i, wb_wdata, wb_wreg, wb_wd); end
      n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid_%0d: got %b expected 1", i, wb_valid); end
    end
    n_checks++; if (stat_bubble_cnt !== exp_bub) begin n_fail++; $display("FAIL hold_bub_cnt: got %0d expected %0d", stat_bubble_cnt, exp_bub); end
    flush = 1'b1;
    step("flush");
`ifdef MEM_WB_STATS_EN
    exp_flush = sat_inc(exp_flush);
`endif
    flush = 1'b0;
    n_checks++; if (wb_wdata !== '0 || wb_wreg !== '0 || wb_wd !== '0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_payload: got wdata=%h wreg=%b wd=%h valid=%b expected zeros", wb_wdata, wb_wreg, wb_wd, wb_valid); end
    n_checks++; if (stat_flush_cnt !== exp_flush) begin n_fail++; $display("FAIL flush_cnt: got %0d expected %0d", stat_flush_cnt, exp_flush); end
    n_checks++; if (stat_bubble_cnt !== exp_bub) begin n_fail++; $display("FAIL flush_bub_cnt: got %0d expected %0d", stat_bubble_cnt, exp_bub); end
  endtask

  task automatic test_multi_channel();
    stall = '0; flush = 1'b0;
    mem_wd = {5'd4, 5'd4}; mem_wreg = 2'b11; mem_wdata = {32'hB, 32'hA};
    step("multi");
    n_checks++; if (wb_wd !== {5'd4, 5'd4} || wb_wreg !== 2'b11) begin n_fail++; $display("FAIL multi_addr: got wd=%h wreg=%b expected 084/11", wb_wd, wb_wreg); end
    n_checks++; if (wb_wdata !== {32'hB, 32'hA}) begin n_fail++; $display("FAIL multi_data: got %h expected 0000000b0000000a", wb_wdata); end
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL multi_valid: got %b expected 1", wb_valid); end
  endtask

  task automatic test_back_to_back();
    logic [NUM_WCH*DATA_W-1:0] prev;
    stall = '0; flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      prev = wb_wdata;
      mem_wd = {5'(i + 8), 5'(i + 1)}; mem_wreg = 2'(i);
      mem_wdata = {32'hC0DE0000 + 32'(i), 32'h1000 + 32'(i * 3)};
      #1;
      n_checks++; if (wb_wdata !== prev) begin n_fail++; $display("FAIL b2b_comb_%0d: got %h expected %h", i, wb_wdata, prev); end
      step("b2b");
      n_checks++; if (wb_wd !== {5'(i + 8), 5'(i + 1)} || wb_wreg !== 2'(i)) begin n_fail++; $display("FAIL b2b_addr_%0d: got wd=%h wreg=%b", i, wb_wd, wb_wreg); end
      n_checks++; if (wb_wdata !== {32'hC0DE0000 + 32'(i), 32'h1000 + 32'(i * 3)}) begin n_fail++; $display("FAIL b2b_data_%0d: got %h", i, wb_wdata); end
    end
  endtask

  task automatic test_saturation();
    stall = 6'b011111; flush = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step("sat_bubble");
`ifdef MEM_WB_STATS_EN
      exp_bub = sat_inc(exp_bub);
`endif
      n_checks++; if (stat_bubble_cnt !== exp_bub) begin n_fail++; $display("FAIL sat_cnt_%0d: got %0d expected %0d", i, stat_bubble_cnt, exp_bub); end
    end
`ifdef MEM_WB_STATS_EN
    n_checks++; if (stat_bubble_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_final: got %0d expected 15", stat_bubble_cnt); end
`else
    n_checks++; if (stat_bubble_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_final: got %0d expected 0", stat_bubble_cnt); end
`endif
    n_checks++; if (stat_flush_cnt !== exp_flush) begin n_fail++; $display("FAIL sat_flush_cnt: got %0d expected %0d", stat_flush_cnt, exp_flush); end
  endtask

  task automatic test_reset_mid_hold();
    stall = '0;
    mem_wd = {5'd1, 5'd9}; mem_wreg = 2'b11; mem_wdata = {32'h77, 32'h66};
    step("advance");
    stall = 6'b111111;
    step("hold");
    n_checks++; if (wb_wdata !== {32'h77, 32'h66} || wb_valid !== 1'b1) begin n_fail++; $display("FAIL mh_hold: got %h valid=%b", wb_wdata, wb_valid); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (wb_wdata !== '0 || wb_wreg !== '0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL mh_reset: got wdata=%h wreg=%b valid=%b expected zeros", wb_wdata, wb_wreg, wb_valid); end
    n_checks++; if ({stat_bubble_cnt, stat_flush_cnt} !== '0) begin n_fail++; $display("FAIL mh_counters: got %0d/%0d expected 0/0", stat_bubble_cnt, stat_flush_cnt); end
    @(negedge clk) rst = 1'b1;
    step("hold_after_rst");
    n_checks++; if (wb_valid !== 1'b0 || wb_wdata !== '0) begin n_fail++; $display("FAIL mh_stays_empty: got valid=%b wdata=%h", wb_valid, wb_wdata); end
  endtask

  initial begin
    test_reset();
    test_advance();
    test_bubble();
    test_hold_flush();
    test_multi_channel();
    test_back_to_back();
    test_saturation();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM→WB pipeline register for the OpenMIPS core: it latches every write-back side effect produced by the memory stage and presents it to the register file, HI/LO unit, CP0 and LLbit register one cycle later. It supersedes the fixed single-port MEM/WB latch. It generalises the write-back payload to `NUM_WCH` register-file write channels and adds CP0/LLbit write channels, a pipeline flush, a `wb_valid` flag and optional bubble/flush statistics counters.

## Interface
Parameters:
- `DATA_W`, 32: width of register, HI, LO and CP0 data.
- `ADDR_W`, 5: register-file address width.
- `NUM_WCH`, 1: number of register-file write channels (1..4).
- `STALL_W`, 6: width of the stall vector from the stall controller.
- `STAGE`, 4: index of this register's stall bit; `STAGE+1` must be `< STALL_W`.
- `CNT_W`, 32: statistics counter width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `stall`  in  STALL_W  per-stage stop request, 1 = stop.
- `flush`  in  1  exception/eret flush, 1 = discard.
- `mem_wd`  in  NUM_WCH*ADDR_W  dest addresses, channel k at `[k*ADDR_W +: ADDR_W]`.
- `mem_wreg`  in  NUM_WCH  per-channel write enables.
- `mem_wdata`  in  NUM_WCH*DATA_W  per-channel write data.
- `mem_hi`, `mem_lo`  in  DATA_W  each  HI/LO values.
- `mem_whilo`  in  1  HI/LO write enable.
- `mem_cp0_we`  in  1  CP0 write enable.
- `mem_cp0_waddr`  in  5  CP0 register address.
- `mem_cp0_wdata`  in  DATA_W  CP0 write data.
- `mem_llbit_we`, `mem_llbit_value`  in  1 each  LLbit write.
- `wb_*`  out  widths as the matching `mem_*` inputs  registered copies.
- `wb_valid`  out  1  1 = the current WB contents came from a real advance, not a bubble.
- `stat_bubble_cnt`, `stat_flush_cnt`  out  CNT_W each  statistics counters.

## Operation
Per rising edge, the first matching row wins:
1. **Flush:** `flush==1`. Load the bubble: all enables 0, addresses 0 (NOP register), data 0, `wb_valid=0`.
2. **Bubble:** `stall[STAGE]==1 && stall[STAGE+1]==0`. Load the bubble, as in row 1.
3. **Hold:** `stall[STAGE]==1 && stall[STAGE+1]==1`. All `wb_*` and `wb_valid` keep their values.
4. **Advance:** `stall[STAGE]==0`. Every `wb_*` is loaded from `mem_*`, and `wb_valid` is set to 1.

Other rules:
- `flush` overrides hold. A stalled-and-held entry is discarded on flush.
- Channels are independent. No collision check is made: two channels naming the same address are passed through, and the register file resolves them (higher index wins).
- Bubble data is forced to 0 even though the enable is 0. This keeps forwarding comparators quiet.
- State machine: implicit two-state, VALID/BUBBLE, tracked by `wb_valid`.
  - Advance → VALID.
  - Flush or bubble → BUBBLE.
  - Hold → stay in the current state.

## Timing
- Latency is 1 cycle from `mem_*` to `wb_*` on advance. There is no combinational path from inputs to outputs.
- Reset (`rst==0`), asynchronous: every output goes to 0 immediately, including `wb_valid` and both counters, and stays there until the first edge after release.
- Reset asserted mid-hold discards the held entry.
- `stall` and `flush` are sampled on the same edge as the data. A change takes effect on the `wb_*` outputs after that edge.
- Counters update on the same edge as the event they count.

## Configuration
- `MEM_WB_STATS_EN` defined:
  - `stat_bubble_cnt` increments on each row-2 edge.
  - `stat_flush_cnt` increments on each row-1 edge.
  - Both saturate at all-ones; there is no wrap.
- `MEM_WB_STATS_EN` not defined: the counters are not built, and both ports are tied to constant 0.
- Pipeline behaviour is identical either way.

## Structure
Shared package/defines `pipe_pkg` holds:
- the stall/no-stop encodings;
- the NOP register address and zero word;
- the default stage indices (IF=0 … WB=5);
- the CP0 address width;
- the bubble-record field list, so the other stage registers reuse it.

One sub-module, `sat_counter` (`CNT_W`, `inc`, `clr`, `q`), is instantiated twice under `MEM_WB_STATS_EN`.

## Test plan
- **Reset:** drive all inputs nonzero, then assert `rst=0` between edges → all outputs read 0 immediately, before the next edge.
- **Advance:** set `mem_wd=5'd3`, `mem_wreg=1`, `mem_wdata=32'hDEADBEEF`, `stall=0`. After one edge → `wb_wd=3`, `wb_wdata=DEADBEEF`, `wb_valid=1`.
- **Bubble:** set `stall=6'b011111`, `STAGE=4`. After the edge → `wb_wreg=0`, `wb_wdata=0`, `wb_valid=0`, and `stat_bubble_cnt` goes from 0 to 1 (stats on).
- **Hold then flush:** with `wb_wdata=32'h1234`, apply `stall=6'b111111` for 3 cycles → output is unchanged. Then `flush=1` with the stall still high → bubble output, and `stat_flush_cnt=1`.
- **Multi-channel:** `NUM_WCH=2`, channel 0 = (r4, 0xA), channel 1 = (r4, 0xB), both enabled → both are passed through unchanged and `wb_valid=1`.
- **Saturation:** `CNT_W=4`, 20 consecutive bubbles → `stat_bubble_cnt=15`. Without the macro, both counters read 0 throughout.
